// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master and its front-end controllers:
// the arbiter state encoding and the width helpers for slave index and byte count.
package spi_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t XFER  = 2'd1;
    localparam state_t DRAIN = 2'd2;
    localparam state_t DONE  = 2'd3;

    // An index is never narrower than 1 bit, even with a single slave or requester.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int max_bytes);
        return $clog2(max_bytes + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first set request at or after ptr wins,
// with the search wrapping modulo N. Pure logic, so any shared-bus controller can reuse it.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          valid
);

    int            k;
    logic [PW-1:0] kk;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        k     = 0;
        kk    = '0;
        for (int off = 0; off < N; off++) begin
            k = int'(ptr) + off;
            if (k >= N) k = k - N;
            kk = PW'(k);
            if (!valid && req[kk]) begin
                valid     = 1'b1;
                grant[kk] = 1'b1;
                idx       = kk;
            end
        end
    end

endmodule

// File: rtl/spi_cs_arbiter.sv
// Shares one multi-CS SPI master between NUM_REQ clients. A grant covers a whole
// CS frame and is released only after the master reports ready again.
module spi_cs_arbiter
    import spi_pkg::*;
#(
    parameter int NUM_REQ          = 3,
    parameter int NUM_SLAVES       = 4,
    parameter int MAX_BYTES_PER_CS = 2,
    parameter int SW               = sel_width(NUM_SLAVES),
    parameter int CW               = cnt_width(MAX_BYTES_PER_CS)
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic [NUM_REQ-1:0]    i_Req,
    input  logic [NUM_REQ*SW-1:0] i_Req_Slave,
    input  logic [NUM_REQ*CW-1:0] i_Req_Count,
    input  logic [NUM_REQ*8-1:0]  i_Req_TX_Byte,
    input  logic [NUM_REQ-1:0]    i_Req_TX_DV,
    output logic [NUM_REQ-1:0]    o_Req_TX_Ready,
    output logic [NUM_REQ-1:0]    o_Grant,
    output logic [NUM_REQ-1:0]    o_Req_RX_DV,
    output logic [7:0]            o_Req_RX_Byte,
    output logic [NUM_REQ-1:0]    o_Done,
    output logic [CW-1:0]         o_M_TX_Count,
    output logic [SW-1:0]         o_M_Slave_Select,
    output logic [7:0]            o_M_TX_Byte,
    output logic                  o_M_TX_DV,
    input  logic                  i_M_TX_Ready,
    input  logic                  i_M_RX_DV,
    input  logic [7:0]            i_M_RX_Byte
);

    localparam int            IW      = sel_width(NUM_REQ);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BYTES_PER_CS);

    state_t             state, state_nxt;
    logic [IW-1:0]      rr_ptr, gidx;
    logic [NUM_REQ-1:0] grant;
    logic [SW-1:0]      slave;
    logic [CW-1:0]      count, tx_cnt, rx_cnt;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IW-1:0]      pick_idx;
    logic               pick_valid;
    logic [CW-1:0]      pick_count;
    logic               tx_open, rx_open, tx_fire, rx_fire;

    rr_arbiter #(.N(NUM_REQ), .PW(IW)) u_rr (
        .req   (i_Req),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        pick_count = i_Req_Count[int'(pick_idx)*CW +: CW];
        if (pick_count > MAX_CNT) pick_count = MAX_CNT;
    end

    // Both counters stop at the latched count, so they can never wrap.
    assign tx_open = (tx_cnt < count);
    assign rx_open = (rx_cnt < count);
    assign tx_fire = (state == XFER) && i_Req_TX_DV[gidx] && tx_open;
    assign rx_fire = (state == XFER) && i_M_RX_DV && rx_open;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_valid) state_nxt = (pick_count == '0) ? DONE : XFER;
            XFER:    if (rx_fire && (rx_cnt + 1'b1 == count)) state_nxt = DRAIN;
            DRAIN:   if (i_M_TX_Ready) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame context is captured once at grant time; later changes on the
    // requester's slave/count inputs have no effect until the next frame.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            rr_ptr <= '0;
            gidx   <= '0;
            grant  <= '0;
            slave  <= '0;
            count  <= '0;
            tx_cnt <= '0;
            rx_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (pick_valid) begin
                    grant  <= pick_grant;
                    gidx   <= pick_idx;
                    slave  <= i_Req_Slave[int'(pick_idx)*SW +: SW];
                    count  <= pick_count;
                    tx_cnt <= '0;
                    rx_cnt <= '0;
                end
                XFER: begin
                    if (tx_fire) tx_cnt <= tx_cnt + 1'b1;
                    if (rx_fire) rx_cnt <= rx_cnt + 1'b1;
                end
                DONE: begin
                    grant  <= '0;
                    rr_ptr <= (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_Grant          = grant;
        o_M_Slave_Select = slave;
        o_M_TX_Count     = count;
        o_Req_RX_Byte    = i_M_RX_Byte;
        o_M_TX_Byte      = '0;
        o_M_TX_DV        = 1'b0;
        o_Req_TX_Ready   = '0;
        o_Req_RX_DV      = '0;
        o_Done           = '0;
        case (state)
            XFER: begin
                o_M_TX_Byte          = i_Req_TX_Byte[int'(gidx)*8 +: 8];
                o_M_TX_DV            = tx_fire;
                o_Req_TX_Ready[gidx] = i_M_TX_Ready && tx_open;
                o_Req_RX_DV[gidx]    = rx_fire;
            end
            DONE:    o_Done = grant;
            default: ;
        endcase
    end

endmodule

// File: doc/spi_cs_arbiter.md
Name: spi_cs_arbiter

Overview:
- Round-robin arbiter that shares one multi-CS SPI master (`i_TX_Count` / `i_Slave_Select` front end) between NUM_REQ requesters.
- The grant is held for one whole CS frame:
  - latches the winner's slave index and byte count;
  - muxes that requester's TX bytes to the master;
  - routes RX strobes back to it;
  - releases only after the master is ready again (CS released, inactive time elapsed).
- Sits between host-side clients (sensor poller, config engine, CPU port) and the SPI master.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- NUM_SLAVES, 4, slave count of the attached master.
- MAX_BYTES_PER_CS, 2, maximum bytes per frame; matches the master.
- SW, $clog2(NUM_SLAVES), slave index width (derived).
- CW, $clog2(MAX_BYTES_PER_CS+1), byte count width (derived).

Ports:
- i_Clk  in  1  system clock.
- i_Rst  in  1  synchronous, active-high reset.
- i_Req  in  NUM_REQ  per-requester frame request; level, held until o_Done.
- i_Req_Slave  in  NUM_REQ*SW  packed target slave per requester.
- i_Req_Count  in  NUM_REQ*CW  packed byte count per requester.
- i_Req_TX_Byte  in  NUM_REQ*8  packed TX byte per requester.
- i_Req_TX_DV  in  NUM_REQ  per-requester TX byte strobe.
- o_Req_TX_Ready  out  NUM_REQ  TX ready; only the granted bit can be 1.
- o_Grant  out  NUM_REQ  one-hot grant, registered.
- o_Req_RX_DV  out  NUM_REQ  RX strobe; only the granted bit can be 1.
- o_Req_RX_Byte  out  8  RX byte, broadcast to all requesters.
- o_Done  out  NUM_REQ  one-cycle frame-complete pulse to the granted requester.
- o_M_TX_Count  out  CW  to master `i_TX_Count`.
- o_M_Slave_Select  out  SW  to master `i_Slave_Select`.
- o_M_TX_Byte  out  8  to master `i_TX_Byte`.
- o_M_TX_DV  out  1  to master `i_TX_DV`.
- i_M_TX_Ready  in  1  from master `o_TX_Ready`.
- i_M_RX_DV  in  1  from master `o_RX_DV`.
- i_M_RX_Byte  in  8  from master `o_RX_Byte`.

Behaviour:
- Reset (i_Rst=1 at a clock edge): state IDLE, rr pointer=0, tx_cnt=rx_cnt=0. o_Grant, o_Done, o_Req_TX_Ready, o_Req_RX_DV and o_M_TX_DV are all 0. o_M_TX_Count=0, o_M_Slave_Select=0.
- Reset mid-frame aborts immediately with no o_Done. The master shares i_Rst through the system reset wrapper.

States and transitions:
- IDLE: if any i_Req bit is set, pick the first set bit at or after the rr pointer, wrapping modulo NUM_REQ.
  - Latch its slave index and count into o_M_Slave_Select and o_M_TX_Count.
  - Clamp the count to MAX_BYTES_PER_CS if larger.
  - Set o_Grant one-hot on the next edge (request-to-grant latency: 1 cycle).
  - Next state: XFER, or DONE if the latched count is 0 (no master activity).
- XFER: combinational mux on the granted requester only.
  - o_M_TX_Byte = granted TX byte.
  - o_M_TX_DV = granted i_Req_TX_DV AND (tx_cnt < count).
  - o_Req_TX_Ready[g] = i_M_TX_Ready AND (tx_cnt < count).
  - tx_cnt increments on each forwarded DV.
  - Each i_M_RX_DV pulses o_Req_RX_DV[g] in the same cycle, with o_Req_RX_Byte = i_M_RX_Byte, and increments rx_cnt.
  - When rx_cnt reaches count, go to DRAIN.
- DRAIN: wait for i_M_TX_Ready=1, which shows the master has returned to idle after the CS inactive time. Then go to DONE.
- DONE: pulse o_Done[g] for 1 cycle, clear o_Grant, set rr pointer = g+1 mod NUM_REQ, go to IDLE.
  - Minimum 1 idle cycle between frames.

Rules and boundary cases:
- Non-granted requesters see TX_Ready=0 and RX_DV=0. Their TX_DV, and any change to i_Req_Slave / i_Req_Count, are ignored while another requester holds the grant.
- A granted TX_DV beyond count (tx_cnt==count) is dropped, not forwarded.
- i_Req deassertion during XFER/DRAIN is ignored; the frame completes.
- A request that stays high after o_Done competes again; rr rotation guarantees other requesters are served first.
- Simultaneous requests resolve strictly by rotating priority. There is no starvation: worst-case wait is NUM_REQ-1 frames.
- Counters are CW bits wide and never wrap, because they saturate at count.

Decomposition:
- Shared package spi_pkg holds:
  - the state encoding localparams (IDLE, XFER, DRAIN, DONE);
  - the SW and CW width functions, shared with the master.
- One sub-module, rr_arbiter: combinational round-robin priority picker with pointer input, request vector in, one-hot grant out. It is reused later by other shared-bus controllers.

Test Plan:
- Single request: i_Req=001, slave 2, count 2, bytes A5 then 3C.
  - o_Grant=001 one cycle later; master sees Slave_Select=2, Count=2.
  - Two RX_DV reach requester 0; o_Done[0] pulses once after i_M_TX_Ready returns.
- Simultaneous i_Req=111 from reset: grants in order 0, 1, 2. Requester 0 holds its request and re-requests; the next grant goes to 1 (rotation holds).
- Count 0 on requester 1: o_Grant=010 then o_Done[1], with o_M_TX_DV never asserted.
- Granted requester strobes 3 bytes with count 2: only 2 o_M_TX_DV pulses; the third is dropped.
- Non-granted requester 2 pulses TX_DV during requester 0's frame: no o_M_TX_DV from it; o_Req_TX_Ready[2] stays 0.
- i_Rst asserted mid-XFER after 1 byte: next cycle all outputs are 0, state is IDLE, no o_Done. After reset, a fresh request is served from pointer 0.
